// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the ALU request driver.
//   DATASIZE / OUTPUTSIZE / OPWIDTH / TAGWIDTH : interface widths (result is 2*DATASIZE)
//   opcode_t    : opaque ALU opcode, passed through undecoded
//   drv_state_t : request FSM states
//   res_entry_t : one result FIFO entry {data, opcode, tag}
package alu_pkg;

   localparam int unsigned DATASIZE   = 8;
   localparam int unsigned OUTPUTSIZE = 2 * DATASIZE;
   localparam int unsigned OPWIDTH    = 4;
   localparam int unsigned TAGWIDTH   = 4;

   typedef logic [OPWIDTH-1:0] opcode_t;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      WAIT
   } drv_state_t;

   typedef struct packed {
      logic [OUTPUTSIZE-1:0] data;
      opcode_t               opcode;
      logic [TAGWIDTH-1:0]   tag;
   } res_entry_t;

   localparam int unsigned ENTRY_W = $bits(res_entry_t);

endpackage

// File: rtl/alu_res_fifo.sv
// alu_res_fifo: result queue, DEPTH entries of res_entry_t, order preserving.
//   clk_i, rst_i  : clock, synchronous active-high reset (flushes the queue)
//   push_i        : write push_data_i at the tail (ignored when full)
//   pop_i         : drop the head (ignored when empty)
//   valid_o       : head entry present
//   head_o        : head entry, zero while empty
//   count_o       : occupancy
// A push becomes visible the cycle after it is written (no fall-through).
module alu_res_fifo
   import alu_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [ENTRY_W-1:0]       push_data_i,
   input  logic                     pop_i,
   output logic                     valid_o,
   output logic [ENTRY_W-1:0]       head_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]    wr_q, wr_d;
   logic [PtrW-1:0]    rd_q, rd_d;
   logic [CntW-1:0]    count_q, count_d;
   logic               do_push, do_pop;

   assign valid_o = (count_q != '0);
   assign do_push = push_i && (count_q != FullCnt);
   assign do_pop  = pop_i && valid_o;

   // Power-of-two depth: pointers wrap by natural overflow.
   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (do_push) begin
         wr_d = wr_q + PtrW'(1);
      end
      if (do_pop) begin
         rd_d = rd_q + PtrW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset; the head is masked while the queue is empty.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_q] <= push_data_i;
      end
   end

   assign head_o  = valid_o ? mem_q[rd_q] : '0;
   assign count_o = count_q;

endmodule

// File: rtl/alu_req_driver.sv
// alu_req_driver: initiator side of an ALU operand/opcode/result interface.
// Accepts one command at a time, drives registered operands to the ALU, waits
// ALU_LATENCY cycles, captures the result and queues it with opcode and tag.
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o    : command handshake
//   cmd_in1_i, cmd_in2_i         : operands
//   cmd_opcode_i, cmd_tag_i      : opcode (not decoded) and user tag
//   alu_in1_o, alu_in2_o         : registered operands to the ALU
//   alu_opcode_o                 : registered opcode to the ALU
//   alu_result_i                 : ALU result, valid ALU_LATENCY cycles after operands
//   res_valid_o / res_ready_i    : result queue handshake
//   res_data_o, res_opcode_o,
//   res_tag_o                    : queue head
//   busy_o                       : an operation is in flight
//   res_count_o                  : queue occupancy
module alu_req_driver
   import alu_pkg::*;
#(
   parameter int unsigned ALU_LATENCY = 0,
   parameter int unsigned RES_DEPTH   = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        cmd_valid_i,
   output logic                        cmd_ready_o,
   input  logic [DATASIZE-1:0]         cmd_in1_i,
   input  logic [DATASIZE-1:0]         cmd_in2_i,
   input  logic [OPWIDTH-1:0]          cmd_opcode_i,
   input  logic [TAGWIDTH-1:0]         cmd_tag_i,
   output logic [DATASIZE-1:0]         alu_in1_o,
   output logic [DATASIZE-1:0]         alu_in2_o,
   output logic [OPWIDTH-1:0]          alu_opcode_o,
   input  logic [OUTPUTSIZE-1:0]       alu_result_i,
   output logic                        res_valid_o,
   input  logic                        res_ready_i,
   output logic [OUTPUTSIZE-1:0]       res_data_o,
   output logic [OPWIDTH-1:0]          res_opcode_o,
   output logic [TAGWIDTH-1:0]         res_tag_o,
   output logic                        busy_o,
   output logic [$clog2(RES_DEPTH):0]  res_count_o
);

   localparam int unsigned CntW  = $clog2(RES_DEPTH) + 1;
   localparam int unsigned WcntW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY + 1) : 1;
   localparam logic [WcntW-1:0] WcntInit = WcntW'(ALU_LATENCY);
   localparam logic [CntW-1:0]  FullCnt  = CntW'(RES_DEPTH);

   drv_state_t            state_q, state_d;
   logic [WcntW-1:0]      wcnt_q, wcnt_d;
   logic [DATASIZE-1:0]   in1_q, in1_d;
   logic [DATASIZE-1:0]   in2_q, in2_d;
   opcode_t               opcode_q, opcode_d;
   logic [TAGWIDTH-1:0]   tag_q, tag_d;

   logic                  push;
   logic                  cmd_ready;
   res_entry_t            push_entry;
   res_entry_t            head_entry;
   logic [ENTRY_W-1:0]    head_raw;
   logic [CntW-1:0]       fifo_count;

   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      in1_d     = in1_q;
      in2_d     = in2_q;
      opcode_d  = opcode_q;
      tag_d     = tag_q;
      push      = 1'b0;
      cmd_ready = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Only one op is ever in flight, so a free slot now guarantees room at push time.
            cmd_ready = (fifo_count < FullCnt);
            if (cmd_valid_i && cmd_ready) begin
               in1_d    = cmd_in1_i;
               in2_d    = cmd_in2_i;
               opcode_d = cmd_opcode_i;
               tag_d    = cmd_tag_i;
               state_d  = DRIVE;
            end
         end
         DRIVE: begin
            if (ALU_LATENCY == 0) begin
               push    = 1'b1;
               state_d = IDLE;
            end else begin
               wcnt_d  = WcntInit;
               state_d = WAIT;
            end
         end
         WAIT: begin
            wcnt_d = wcnt_q - WcntW'(1);
            if (wcnt_q == WcntW'(1)) begin
               push    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         wcnt_q   <= '0;
         in1_q    <= '0;
         in2_q    <= '0;
         opcode_q <= '0;
         tag_q    <= '0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         in1_q    <= in1_d;
         in2_q    <= in2_d;
         opcode_q <= opcode_d;
         tag_q    <= tag_d;
      end
   end

   assign push_entry = '{data: alu_result_i, opcode: opcode_q, tag: tag_q};

   alu_res_fifo #(
      .DEPTH (RES_DEPTH)
   ) u_res_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (res_ready_i),
      .valid_o     (res_valid_o),
      .head_o      (head_raw),
      .count_o     (fifo_count)
   );

   assign head_entry   = res_entry_t'(head_raw);
   assign res_data_o   = head_entry.data;
   assign res_opcode_o = head_entry.opcode;
   assign res_tag_o    = head_entry.tag;
   assign res_count_o  = fifo_count;

   assign cmd_ready_o  = cmd_ready;
   assign alu_in1_o    = in1_q;
   assign alu_in2_o    = in2_q;
   assign alu_opcode_o = opcode_q;
   assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_req_driver.sv
// Bench for alu_req_driver: instance 0 uses a combinational ALU, instance 1 a
// 3-cycle pipelined ALU; both ALUs compute in1*in2. A transaction-level model
// per instance predicts handshakes, occupancy, operands and result order.
module tb_alu_req_driver;
   import alu_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned LAT1  = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst [2];
   logic        cmd_valid [2];
   logic        cmd_ready [2];
   logic [7:0]  cmd_in1 [2];
   logic [7:0]  cmd_in2 [2];
   logic [3:0]  cmd_opcode [2];
   logic [3:0]  cmd_tag [2];
   logic [7:0]  alu_in1 [2];
   logic [7:0]  alu_in2 [2];
   logic [3:0]  alu_opcode [2];
   logic [15:0] alu_result [2];
   logic        res_valid [2];
   logic        res_ready [2];
   logic [15:0] res_data [2];
   logic [3:0]  res_opcode [2];
   logic [3:0]  res_tag [2];
   logic        busy [2];
   logic [2:0]  res_count [2];

   alu_req_driver #(.ALU_LATENCY(0), .RES_DEPTH(DEPTH)) dut0 (
      .clk_i(clk), .rst_i(rst[0]), .cmd_valid_i(cmd_valid[0]), .cmd_ready_o(cmd_ready[0]),
      .cmd_in1_i(cmd_in1[0]), .cmd_in2_i(cmd_in2[0]), .cmd_opcode_i(cmd_opcode[0]),
      .cmd_tag_i(cmd_tag[0]), .alu_in1_o(alu_in1[0]), .alu_in2_o(alu_in2[0]),
      .alu_opcode_o(alu_opcode[0]), .alu_result_i(alu_result[0]), .res_valid_o(res_valid[0]),
      .res_ready_i(res_ready[0]), .res_data_o(res_data[0]), .res_opcode_o(res_opcode[0]),
      .res_tag_o(res_tag[0]), .busy_o(busy[0]), .res_count_o(res_count[0])
   );

   alu_req_driver #(.ALU_LATENCY(LAT1), .RES_DEPTH(DEPTH)) dut1 (
      .clk_i(clk), .rst_i(rst[1]), .cmd_valid_i(cmd_valid[1]), .cmd_ready_o(cmd_ready[1]),
      .cmd_in1_i(cmd_in1[1]), .cmd_in2_i(cmd_in2[1]), .cmd_opcode_i(cmd_opcode[1]),
      .cmd_tag_i(cmd_tag[1]), .alu_in1_o(alu_in1[1]), .alu_in2_o(alu_in2[1]),
      .alu_opcode_o(alu_opcode[1]), .alu_result_i(alu_result[1]), .res_valid_o(res_valid[1]),
      .res_ready_i(res_ready[1]), .res_data_o(res_data[1]), .res_opcode_o(res_opcode[1]),
      .res_tag_o(res_tag[1]), .busy_o(busy[1]), .res_count_o(res_count[1])
   );

   // ALU models: combinational multiply, and multiply delayed through 3 registers.
   logic [15:0] pipe_q [3];
   always @(posedge clk) begin
      pipe_q[0] <= 16'(alu_in1[1]) * 16'(alu_in2[1]);
      pipe_q[1] <= pipe_q[0];
      pipe_q[2] <= pipe_q[1];
   end
   assign alu_result[0] = 16'(alu_in1[0]) * 16'(alu_in2[0]);
   assign alu_result[1] = pipe_q[2];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Transaction model: queue of expected {product, opcode, tag}, one pending op
   // that lands in the queue after 1+latency busy cycles.
   logic [23:0] m_q [2][DEPTH];
   int          m_head [2];
   int          m_cnt [2];
   int          m_left [2];
   bit          m_busy [2];
   logic [23:0] m_pend [2];
   logic [19:0] m_ops [2];

   task automatic model_step(input int k);
      int          lat;
      bit          exp_ready;
      bit          push;
      logic [5:0]  exp_ctl;
      lat       = (k == 0) ? 0 : LAT1;
      exp_ready = !m_busy[k] && (m_cnt[k] < DEPTH);
      exp_ctl   = {m_busy[k], exp_ready, m_cnt[k] != 0, 3'(m_cnt[k])};
      check($sformatf("d%0d.ctl", k), {busy[k], cmd_ready[k], res_valid[k], res_count[k]},
            exp_ctl);
      check($sformatf("d%0d.alu_ops", k), {alu_in1[k], alu_in2[k], alu_opcode[k]}, m_ops[k]);
      if (m_cnt[k] != 0) begin
         check($sformatf("d%0d.head", k), {res_data[k], res_opcode[k], res_tag[k]},
               m_q[k][m_head[k]]);
      end
      if (rst[k]) begin
         m_head[k] = 0;
         m_cnt[k]  = 0;
         m_left[k] = 0;
         m_busy[k] = 0;
         m_ops[k]  = '0;
      end else begin
         push = m_busy[k] && (m_left[k] == 0);
         if (res_ready[k] && m_cnt[k] != 0) begin
            m_head[k] = (m_head[k] + 1) % DEPTH;
            m_cnt[k]--;
         end
         if (push) begin
            m_q[k][(m_head[k] + m_cnt[k]) % DEPTH] = m_pend[k];
            m_cnt[k]++;
            m_busy[k] = 0;
         end else if (m_busy[k]) begin
            m_left[k]--;
         end
         if (cmd_valid[k] && exp_ready) begin
            m_busy[k] = 1;
            m_left[k] = lat;
            m_ops[k]  = {cmd_in1[k], cmd_in2[k], cmd_opcode[k]};
            m_pend[k] = {16'(cmd_in1[k]) * 16'(cmd_in2[k]), cmd_opcode[k], cmd_tag[k]};
         end
      end
   endtask

   always @(negedge clk) begin
      model_step(0);
      model_step(1);
   end

   task automatic issue(input int k, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] op, input logic [3:0] tg);
      bit done;
      done          = 0;
      cmd_in1[k]    = a;
      cmd_in2[k]    = b;
      cmd_opcode[k] = op;
      cmd_tag[k]    = tg;
      cmd_valid[k]  = 1'b1;
      for (int i = 0; i < 64 && !done; i++) begin
         @(negedge clk);
         done = cmd_ready[k];
         @(posedge clk); #1;
      end
      cmd_valid[k] = 1'b0;
      check($sformatf("d%0d.issue_accepted", k), 64'(done), 64'd1);
   endtask

   initial begin
      int n;
      int e;
      for (int k = 0; k < 2; k++) begin
         m_head[k] = 0; m_cnt[k] = 0; m_left[k] = 0; m_busy[k] = 0;
         m_ops[k] = '0; m_pend[k] = '0;
         rst[k] = 1'b1; cmd_valid[k] = 1'b0; cmd_in1[k] = '0; cmd_in2[k] = '0;
         cmd_opcode[k] = '0; cmd_tag[k] = '0; res_ready[k] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst[0] = 1'b0;
      rst[1] = 1'b0;

      // Reset state
      check("rst.res_valid", res_valid[1], 0);
      check("rst.res_count", res_count[1], 0);
      check("rst.res_data", res_data[0], 0);
      check("rst.busy", busy[1], 0);
      check("rst.alu_in1", alu_in1[0], 0);
      check("rst.cmd_ready", cmd_ready[0], 1);

      // 1: combinational ALU, FF*FF
      res_ready[0] = 1'b1;
      cmd_in1[0] = 8'hFF; cmd_in2[0] = 8'hFF; cmd_opcode[0] = 4'h5; cmd_tag[0] = 4'h3;
      cmd_valid[0] = 1'b1;
      @(posedge clk); #1;
      cmd_valid[0] = 1'b0;
      check("t1.alu_in1", alu_in1[0], 8'hFF);
      check("t1.valid_early", res_valid[0], 0);
      @(posedge clk); #1;
      check("t1.res_valid", res_valid[0], 1);
      check("t1.res_data", res_data[0], 16'hFE01);
      check("t1.res_tag", res_tag[0], 4'h3);
      @(posedge clk); #1;

      // 2: latency-3 ALU, 12*34, busy for 4 cycles
      res_ready[1] = 1'b1;
      cmd_in1[1] = 8'h12; cmd_in2[1] = 8'h34; cmd_opcode[1] = 4'h2; cmd_tag[1] = 4'h7;
      cmd_valid[1] = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(posedge clk); #1;
         cmd_valid[1] = 1'b0;
         if (i <= 4) begin
            check("t2.busy", busy[1], 1);
            check("t2.cmd_ready", cmd_ready[1], 0);
         end else begin
            check("t2.busy_done", busy[1], 0);
            check("t2.res_valid", res_valid[1], 1);
            check("t2.res_data", res_data[1], 16'h03A8);
         end
      end

      // 3: fill the queue with res_ready low, then drain in order
      res_ready[0] = 1'b0;
      n = 0;
      cmd_tag[0] = 4'h0; cmd_in1[0] = 8'd5; cmd_in2[0] = 8'd3; cmd_valid[0] = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (cmd_ready[0] && cmd_valid[0]) n++;
         @(posedge clk); #1;
         if (n < 5) begin
            cmd_tag[0] = 4'(n);
            cmd_in1[0] = 8'(n * 37 + 5);
            cmd_in2[0] = 8'(n * 11 + 3);
         end else begin
            cmd_valid[0] = 1'b0;
         end
      end
      check("t3.accepted", n, 4);
      check("t3.count", res_count[0], 4);
      check("t3.cmd_ready", cmd_ready[0], 0);
      res_ready[0] = 1'b1;
      e = 0;
      for (int c = 0; c < 40 && e < 5; c++) begin
         @(negedge clk);
         if (res_valid[0]) begin
            check("t3.order", res_tag[0], 4'(e));
            e++;
         end
         if (cmd_ready[0] && cmd_valid[0]) n++;
         @(posedge clk); #1;
         if (n >= 5) cmd_valid[0] = 1'b0;
      end
      check("t3.popped", e, 5);
      check("t3.fifth", n, 5);

      // 4: simultaneous push and pop at count 2, then wrap-around
      res_ready[1] = 1'b0;
      issue(1, 8'h21, 8'h43, 4'h1, 4'h8);
      issue(1, 8'h05, 8'h07, 4'h2, 4'h9);
      issue(1, 8'h11, 8'h13, 4'h3, 4'hA);
      repeat (3) begin @(posedge clk); #1; end
      res_ready[1] = 1'b1;
      @(posedge clk); #1;
      res_ready[1] = 1'b0;
      check("t4.count", res_count[1], 2);
      check("t4.head", res_tag[1], 4'h9);
      res_ready[1] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         issue(1, 8'($urandom), 8'($urandom), 4'($urandom), 4'(i));
      end
      repeat (8) begin @(posedge clk); #1; end
      check("t4.drained", res_count[1], 0);

      // 5: reset during WAIT with 2 entries queued
      res_ready[1] = 1'b0;
      issue(1, 8'd3, 8'd4, 4'h1, 4'h1);
      issue(1, 8'd5, 8'd6, 4'h2, 4'h2);
      repeat (4) begin @(posedge clk); #1; end
      check("t5.count_pre", res_count[1], 2);
      issue(1, 8'd7, 8'd8, 4'h3, 4'h3);
      @(posedge clk); #1;
      check("t5.busy_pre", busy[1], 1);
      rst[1] = 1'b1;
      @(posedge clk); #1;
      rst[1] = 1'b0;
      check("t5.res_valid", res_valid[1], 0);
      check("t5.res_count", res_count[1], 0);
      check("t5.busy", busy[1], 0);
      check("t5.alu_ops", {alu_in1[1], alu_in2[1], alu_opcode[1]}, 0);
      check("t5.res_data", res_data[1], 0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("t5.no_late_push", res_count[1], 0);
      end

      // 6: head stable under back-pressure while new commands arrive
      res_ready[0] = 1'b0;
      issue(0, 8'h0A, 8'h0B, 4'h9, 4'h6);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         check("t6.valid", res_valid[0], 1);
         check("t6.data", res_data[0], 16'h006E);
         check("t6.tag", res_tag[0], 4'h6);
         check("t6.opcode", res_opcode[0], 4'h9);
         cmd_valid[0] = i[0];
         cmd_in1[0] = 8'($urandom);
         cmd_in2[0] = 8'($urandom);
         cmd_tag[0] = 4'($urandom);
         @(posedge clk); #1;
      end
      cmd_valid[0] = 1'b0;
      res_ready[0] = 1'b1;
      repeat (12) begin @(posedge clk); #1; end

      // Random traffic on both instances, alternating light and heavy back-pressure
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < 2; k++) begin
            rst[k]        = ($urandom_range(0, 299) == 0);
            cmd_valid[k]  = ($urandom_range(0, 2) != 0);
            cmd_in1[k]    = 8'($urandom);
            cmd_in2[k]    = 8'($urandom);
            cmd_opcode[k] = 4'($urandom);
            cmd_tag[k]    = 4'($urandom);
            res_ready[k]  = ((c / 500) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                                 : ($urandom_range(0, 4) == 0);
         end
         @(posedge clk); #1;
      end
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b0;
         cmd_valid[k] = 1'b0;
         res_ready[k] = 1'b1;
      end
      repeat (20) begin @(posedge clk); #1; end
      check("end.count0", res_count[0], 0);
      check("end.count1", res_count[1], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
